// File: rtl/uart_tx_frame_if.sv
// Parallel-side handshake and serial-line bundle for the UART transmit framer.
// The producer uses the master modport and the framer uses the slave modport.
interface uart_tx_frame_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] P_Data;
    logic                  Data_Valid;
    logic                  PAR_EN;
    logic                  PAR_TYP;
    logic                  TX_OUT;
    logic                  Busy;

    modport master (
        output P_Data,
        output Data_Valid,
        output PAR_EN,
        output PAR_TYP,
        input  TX_OUT,
        input  Busy
    );

    modport slave (
        input  P_Data,
        input  Data_Valid,
        input  PAR_EN,
        input  PAR_TYP,
        output TX_OUT,
        output Busy
    );
endinterface

// File: rtl/uart_tx_frame.sv
// UART transmit framer: start bit, LSB-first payload, optional parity, stop bit.
// Runs on the Tx baud clock, emitting one serial bit per CLK cycle.
module uart_tx_frame #(
    parameter int DATA_WIDTH = 8
) (
    input  logic            CLK,
    input  logic            Reset,
    uart_tx_frame_if.slave  bus
);

    localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] data_q;
    logic                  par_en_q;
    logic                  par_bit_q;
    logic                  tx_q, tx_d;
    logic                  busy_q, busy_d;
    logic                  accept;

    // Frame configuration is captured only here, so a busy frame is immune to input changes.
    assign accept = (state_q == IDLE) && bus.Data_Valid;

    // NOTE: the payload register is reset too, so the line starts from a known frame image.
    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            data_q    <= '0;
            par_en_q  <= 1'b0;
            par_bit_q <= 1'b0;
        end else if (accept) begin
            data_q    <= bus.P_Data;
            par_en_q  <= bus.PAR_EN;
            par_bit_q <= (^bus.P_Data) ^ bus.PAR_TYP;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
        end
    end

    // NOTE: every output of this block gets a default first, so no latch is inferred.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        tx_d    = tx_q;
        busy_d  = busy_q;

        unique case (state_q)
            IDLE: begin
                tx_d   = 1'b1;
                busy_d = 1'b0;
                if (bus.Data_Valid) begin
                    state_d = START;
                    tx_d    = 1'b0;
                    busy_d  = 1'b1;
                end
            end
            START: begin
                state_d = DATA;
                cnt_d   = '0;
                tx_d    = data_q[0];
            end
            DATA: begin
                if (cnt_q == LAST_BIT) begin
                    if (par_en_q) begin
                        state_d = PARITY;
                        tx_d    = par_bit_q;
                    end else begin
                        state_d = STOP;
                        tx_d    = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                    tx_d  = data_q[cnt_d];
                end
            end
            PARITY: begin
                state_d = STOP;
                tx_d    = 1'b1;
            end
            STOP: begin
                state_d = IDLE;
                tx_d    = 1'b1;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = IDLE;
                tx_d    = 1'b1;
                busy_d  = 1'b0;
            end
        endcase
    end

    assign bus.TX_OUT = tx_q;
    assign bus.Busy   = busy_q;

endmodule

// File: tb/tb_uart_tx_frame.sv
// Directed self-checking bench for uart_tx_frame: frame shape, parity, back-pressure,
// back-to-back frames and asynchronous reset.
module tb_uart_tx_frame;

    logic CLK;
    logic Reset;
    int   checks;
    int   errors;

    uart_tx_frame_if #(.DATA_WIDTH(8)) bus ();

    uart_tx_frame #(.DATA_WIDTH(8)) dut (
        .CLK   (CLK),
        .Reset (Reset),
        .bus   (bus.slave)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected line value for bit slot i of a frame (slot 0 = start bit).
    function automatic logic exp_bit(input logic [7:0] d, input logic pen,
                                     input logic ptyp, input int i);
        int ones;
        ones = 0;
        for (int k = 0; k < 8; k++) if (d[k]) ones++;
        if (i == 0) return 1'b0;
        if (i <= 8) return d[i-1];
        if (i == 9 && pen) return ptyp ? ((ones % 2) == 0) : ((ones % 2) == 1);
        return 1'b1;
    endfunction

    // Presents a payload at a falling edge; returns just after the accepting rising edge.
    task automatic start_frame(input logic [7:0] d, input logic pen, input logic ptyp);
        @(negedge CLK);
        bus.P_Data     = d;
        bus.PAR_EN     = pen;
        bus.PAR_TYP    = ptyp;
        bus.Data_Valid = 1'b1;
        @(posedge CLK);
    endtask

    // Checks every bit slot of a frame plus the following idle cycle.
    task automatic check_frame(input logic [7:0] d, input logic pen, input logic ptyp,
                               input bit drop_valid, input int inject_at, input string tag);
        int len;
        len = pen ? 11 : 10;
        for (int i = 0; i < len; i++) begin
            @(negedge CLK);
            check($sformatf("%s tx slot %0d", tag, i), bus.TX_OUT, exp_bit(d, pen, ptyp, i));
            check($sformatf("%s busy slot %0d", tag, i), bus.Busy, 1'b1);
            if (i == 0 && drop_valid) bus.Data_Valid = 1'b0;
            if (i == inject_at) begin
                bus.Data_Valid = 1'b1;
                bus.P_Data     = 8'h3C;
                bus.PAR_EN     = 1'b1;
            end
            if (i == inject_at + 1) bus.Data_Valid = 1'b0;
        end
        @(negedge CLK);
        check({tag, " idle tx"}, bus.TX_OUT, 1'b1);
        check({tag, " idle busy"}, bus.Busy, 1'b0);
    endtask

    initial begin
        checks         = 0;
        errors         = 0;
        Reset          = 1'b0;
        bus.P_Data     = '0;
        bus.Data_Valid = 1'b0;
        bus.PAR_EN     = 1'b0;
        bus.PAR_TYP    = 1'b0;

        #12;
        check("reset tx", bus.TX_OUT, 1'b1);
        check("reset busy", bus.Busy, 1'b0);
        @(negedge CLK);
        Reset = 1'b1;
        @(negedge CLK);
        check("post-reset tx", bus.TX_OUT, 1'b1);
        check("post-reset busy", bus.Busy, 1'b0);

        // 0xA5 without parity: 0,1,0,1,0,0,1,0,1,1
        start_frame(8'hA5, 1'b0, 1'b0);
        check_frame(8'hA5, 1'b0, 1'b0, 1'b1, -10, "a5 nopar");

        // 0xA5 with even then odd parity (parity slot 0 then 1)
        start_frame(8'hA5, 1'b1, 1'b0);
        check_frame(8'hA5, 1'b1, 1'b0, 1'b1, -10, "a5 even");
        start_frame(8'hA5, 1'b1, 1'b1);
        check_frame(8'hA5, 1'b1, 1'b1, 1'b1, -10, "a5 odd");

        // Edge payloads
        start_frame(8'h00, 1'b1, 1'b1);
        check_frame(8'h00, 1'b1, 1'b1, 1'b1, -10, "00 odd");
        start_frame(8'hFF, 1'b1, 1'b0);
        check_frame(8'hFF, 1'b1, 1'b0, 1'b1, -10, "ff even");

        // Mid-frame interference: 0x3C / PAR_EN=1 pulse during DATA must be ignored
        start_frame(8'hA5, 1'b0, 1'b0);
        check_frame(8'hA5, 1'b0, 1'b0, 1'b1, 4, "interfere");
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            check($sformatf("no 3c tx %0d", i), bus.TX_OUT, 1'b1);
            check($sformatf("no 3c busy %0d", i), bus.Busy, 1'b0);
        end
        bus.PAR_EN = 1'b0;

        // Back-to-back with Data_Valid held high: exactly one idle cycle between frames
        start_frame(8'h01, 1'b0, 1'b0);
        #1 bus.P_Data = 8'h80;
        check_frame(8'h01, 1'b0, 1'b0, 1'b0, -10, "b2b first");
        check_frame(8'h80, 1'b0, 1'b0, 1'b1, -10, "b2b second");

        // Asynchronous reset in the middle of the data bits
        start_frame(8'hA5, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            @(negedge CLK);
            check($sformatf("pre-reset tx slot %0d", i), bus.TX_OUT, exp_bit(8'hA5, 1'b0, 1'b0, i));
            if (i == 0) bus.Data_Valid = 1'b0;
        end
        #2 Reset = 1'b0;
        #1;
        check("async reset tx", bus.TX_OUT, 1'b1);
        check("async reset busy", bus.Busy, 1'b0);
        @(posedge CLK);
        #1;
        check("held reset tx", bus.TX_OUT, 1'b1);
        check("held reset busy", bus.Busy, 1'b0);
        @(negedge CLK);
        Reset = 1'b1;
        start_frame(8'h5A, 1'b0, 1'b0);
        check_frame(8'h5A, 1'b0, 1'b0, 1'b1, -10, "5a after reset");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_tx_frame.md
Name: uart_tx_frame

Overview:
- UART transmit-side framer: the transmit counterpart of the UART Rx deserializer path.
- Accepts a parallel byte with a valid strobe and emits one serial frame on TX_OUT, one bit per CLK cycle. CLK is the Tx baud-rate clock.
- Frame format: start bit (0), DATA_WIDTH data bits LSB first, optional even/odd parity bit, stop bit (1).
- Sits between the system/register-file side and the physical Tx line; Busy provides back-pressure to the upstream producer.

Parameters:
- DATA_WIDTH, 8, width of the parallel payload in bits.

Ports:
- CLK  input  1  Tx baud clock; all state on rising edge.
- Reset  input  1  asynchronous, active-low reset.
- P_Data  input  DATA_WIDTH  parallel payload; sampled only on acceptance.
- Data_Valid  input  1  payload-valid strobe; honoured only while idle.
- PAR_EN  input  1  1 = insert parity bit; sampled on acceptance.
- PAR_TYP  input  1  0 = even parity, 1 = odd parity; sampled on acceptance.
- TX_OUT  output  1  serial line, registered; idles high.
- Busy  output  1  registered; 1 from start bit through stop bit inclusive.

Behaviour:
- Reset (async, Reset=0):
  - State IDLE; TX_OUT=1; Busy=0.
  - Payload register, parity-config registers and bit counter all cleared.
  - Takes effect immediately, including mid-frame; no partial-frame completion.
- FSM states: IDLE -> START -> DATA -> PARITY -> STOP -> IDLE. PARITY is skipped when the latched PAR_EN=0.
- Acceptance:
  - Occurs on a rising edge with state=IDLE and Data_Valid=1.
  - On that edge: latch P_Data, PAR_EN and PAR_TYP; compute and latch the parity bit; go to START; TX_OUT<=0; Busy<=1.
  - Start bit is therefore visible the cycle after the Data_Valid sample: 1-cycle latency.
- Busy=1: Data_Valid is ignored, and P_Data/PAR_EN/PAR_TYP changes have no effect on the frame in flight.
- START: one cycle at TX_OUT=0, then DATA with bit counter=0.
- DATA:
  - TX_OUT = latched_data[counter]; LSB goes first.
  - Counter increments every cycle.
  - Transition taken after the bit with counter=DATA_WIDTH-1: to PARITY if latched PAR_EN=1, else to STOP.
  - Counter width is clog2(DATA_WIDTH); it never wraps within a frame.
- PARITY:
  - One cycle; TX_OUT = XOR of the latched data, inverted when latched PAR_TYP=1.
  - Even parity makes the total count of ones (data + parity) even; odd parity makes it odd.
- STOP: one cycle at TX_OUT=1, Busy still 1; next edge goes to IDLE with Busy<=0.
- IDLE: TX_OUT=1, Busy=0.
  - Data_Valid=1 in the first IDLE cycle after STOP is accepted, so the minimum inter-frame gap is 1 idle cycle at TX_OUT=1.
- Frame length with Busy=1: 1+DATA_WIDTH+1 cycles (10 for DATA_WIDTH=8) without parity; 1+DATA_WIDTH+2 cycles (11) with parity.
- TX_OUT and Busy are driven from flops only, so TX_OUT is glitch-free.
- Data_Valid held high continuously: a new frame is accepted each time IDLE is reached, i.e. back-to-back frames with 1-cycle idle gaps.

Test Plan:
- After reset, P_Data=0xA5, PAR_EN=0, one-cycle Data_Valid -> next 10 cycles TX_OUT = 0,1,0,1,0,0,1,0,1,1 with Busy=1 throughout; then TX_OUT=1, Busy=0.
- P_Data=0xA5, PAR_EN=1 -> parity bit (cycle 10) = 0 when PAR_TYP=0 and 1 when PAR_TYP=1; 11-cycle frame, stop bit in cycle 11.
- Edge payloads with PAR_EN=1:
  - 0x00 with PAR_TYP=1 -> data all 0, parity 1.
  - 0xFF with PAR_TYP=0 -> data all 1, parity 0.
- Mid-frame interference: start 0xA5 (no parity), then during DATA pulse Data_Valid with P_Data=0x3C and flip PAR_EN=1 -> frame unchanged (10 cycles, 0xA5 bits, no parity); 0x3C is not sent afterwards.
- Back-to-back: Data_Valid held high with 0x01 then 0x80 -> two frames with exactly one TX_OUT=1 idle cycle between the stop bit of frame 1 and the start bit of frame 2.
- Async reset: assert Reset=0 mid-DATA of a 0xA5 frame (between clock edges) -> TX_OUT=1 and Busy=0 immediately. Release, then send 0x5A -> clean, correct 10-cycle frame.
